// File: rtl/tx_word_feeder_pkg.sv
// Shared constants for the transmitter word feeder:
// word width, idle pattern and default buffer depth.
package tx_word_feeder_pkg;

  localparam int WW = 4;
  localparam logic [WW-1:0] IDLE_WORD = 4'b0000;
  localparam int DEFAULT_DEPTH = 8;

endpackage

// File: rtl/tx_word_feeder_word_fifo.sv
// Synchronous FIFO of words; occupancy is the
// difference of two wrap-bit pointers.
import tx_word_feeder_pkg::*;

module word_fifo #(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 3
) (
  input  logic          sclk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [WW-1:0] din_i,
  output logic [WW-1:0] dout_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [WW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          do_push;
  logic          do_pop;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  assign count_o = wptr_q - rptr_q;
  assign full_o  = (count_o == FULL_CNT);
  assign empty_o = (count_o == '0);
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: pointers gate every read.
  always_ff @(posedge sclk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/tx_word_feeder.sv
// Presents buffered words to the serial transmitter,
// advancing on the falling edge of its acknowledge.
import tx_word_feeder_pkg::*;

module tx_word_feeder #(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 3
) (
  input  logic          sclk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [WW-1:0] wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  input  logic          ack,
  output logic [WW-1:0] date,
  output logic          date_vld,
  output logic [7:0]    sent_cnt,
  output logic          underrun,
  output logic          overflow
);

  logic          ack_q;
  logic          ack_fall;
  logic          push;
  logic          pop;
  logic [WW-1:0] head;

  logic [WW-1:0] date_q, date_d;
  logic          vld_q, vld_d;
  logic [7:0]    sent_q, sent_d;
  logic          un_q, un_d;
  logic          ov_q, ov_d;

  word_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .sclk   (sclk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (wr_data),
    .dout_o (head),
    .count_o(count),
    .full_o (full),
    .empty_o(empty)
  );

  assign ack_fall = ack_q & ~ack;
  assign push     = wr_en & ~full;
  // Slot is frozen while the transmitter is mid-latch.
  assign pop      = ~vld_q & ~empty & ~ack & ~ack_q;

  always_comb begin
    date_d = date_q;
    vld_d  = vld_q;
    sent_d = sent_q;
    un_d   = un_q;
    ov_d   = ov_q | (wr_en & full);
    unique case (1'b1)
      ack_fall & vld_q: begin
        sent_d = sent_q + 8'd1;
        vld_d  = 1'b0;
        date_d = IDLE_WORD;
      end
      ack_fall & ~vld_q: un_d = 1'b1;
      pop: begin
        date_d = head;
        vld_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      ack_q  <= 1'b0;
      date_q <= IDLE_WORD;
      vld_q  <= 1'b0;
      sent_q <= '0;
      un_q   <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      ack_q  <= ack;
      date_q <= date_d;
      vld_q  <= vld_d;
      sent_q <= sent_d;
      un_q   <= un_d;
      ov_q   <= ov_d;
    end
  end

  assign date     = date_q;
  assign date_vld = vld_q;
  assign sent_cnt = sent_q;
  assign underrun = un_q;
  assign overflow = ov_q;

endmodule

// File: tb/tb_tx_word_feeder.sv
// Directed bench for tx_word_feeder: vector table
// plus hand sequences for overflow, holds and reset.
module tb_tx_word_feeder;

  logic       sclk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_data = 4'h0;
  logic       ack = 1'b0;
  logic       full, empty, date_vld;
  logic       underrun, overflow;
  logic [3:0] count;
  logic [3:0] date;
  logic [7:0] sent_cnt;
  logic       tx_ser = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 sclk = ~sclk;

  tx_word_feeder #(.DEPTH(8), .AW(3)) dut (
    .sclk    (sclk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .ack     (ack),
    .date    (date),
    .date_vld(date_vld),
    .sent_cnt(sent_cnt),
    .underrun(underrun),
    .overflow(overflow)
  );

  typedef struct {
    logic       wr;
    logic [3:0] wd;
    logic       ak;
    logic [3:0] cnt;
    logic       fl;
    logic       em;
    logic [3:0] dt;
    logic       vl;
    logic [7:0] st;
    logic       un;
    logic       ov;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge sclk);
    rst = 1'b0;
    wr_en = 1'b0;
    ack = 1'b0;
    @(negedge sclk);
    rst = 1'b1;
  endtask

  task automatic ack_pulse();
    @(negedge sclk) ack = 1'b1;
    @(negedge sclk) ack = 1'b0;
    @(posedge sclk);
    @(posedge sclk);
    #1;
  endtask

  // Minimal transmitter: latch on ack rise, shift MSB first.
  task automatic tx_frame(output logic [3:0] w, output bit ok);
    logic [3:0] sh;
    ok = 1'b0;
    w = 4'h0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge sclk);
      if (date_vld) ok = 1'b1;
    end
    if (ok) begin
      ack = 1'b1;
      sh = date;
      for (int b = 0; b < 4; b++) begin
        @(negedge sclk);
        ack = 1'b0;
        tx_ser = sh[3-b];
        w = {w[2:0], tx_ser};
      end
      repeat (6) @(negedge sclk);
    end
  endtask

  initial begin
    logic [3:0] w;
    bit ok;

    tbl[0]  = '{0, 4'h0, 1, 0, 0, 1, 4'h0, 0, 0, 0, 0};
    tbl[1]  = '{0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 0, 1, 0};
    tbl[2]  = '{0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 0, 1, 0};
    tbl[3]  = '{1, 4'hA, 0, 1, 0, 0, 4'h0, 0, 0, 1, 0};
    tbl[4]  = '{1, 4'h5, 0, 1, 0, 0, 4'hA, 1, 0, 1, 0};
    tbl[5]  = '{1, 4'hC, 0, 2, 0, 0, 4'hA, 1, 0, 1, 0};
    tbl[6]  = '{0, 4'h0, 1, 2, 0, 0, 4'hA, 1, 0, 1, 0};
    tbl[7]  = '{0, 4'h0, 0, 2, 0, 0, 4'h0, 0, 1, 1, 0};
    tbl[8]  = '{0, 4'h0, 0, 1, 0, 0, 4'h5, 1, 1, 1, 0};
    tbl[9]  = '{0, 4'h0, 1, 1, 0, 0, 4'h5, 1, 1, 1, 0};
    tbl[10] = '{0, 4'h0, 0, 1, 0, 0, 4'h0, 0, 2, 1, 0};
    tbl[11] = '{0, 4'h0, 0, 0, 0, 1, 4'hC, 1, 2, 1, 0};
    tbl[12] = '{0, 4'h0, 1, 0, 0, 1, 4'hC, 1, 2, 1, 0};
    tbl[13] = '{0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 3, 1, 0};
    tbl[14] = '{0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 3, 1, 0};

    // Reset values
    #12;
    check("rst_outs",
          {count, full, empty, date, date_vld, sent_cnt, underrun, overflow},
          {4'd0, 1'b0, 1'b1, 4'h0, 1'b0, 8'd0, 1'b0, 1'b0});
    @(negedge sclk) rst = 1'b1;
    @(posedge sclk); #1;
    check("rst_hold",
          {count, full, empty, date, date_vld, sent_cnt, underrun, overflow},
          {4'd0, 1'b0, 1'b1, 4'h0, 1'b0, 8'd0, 1'b0, 1'b0});

    // Underrun then in-order delivery
    for (int i = 0; i < 15; i++) begin
      @(negedge sclk);
      wr_en = tbl[i].wr;
      wr_data = tbl[i].wd;
      ack = tbl[i].ak;
      @(posedge sclk); #1;
      check($sformatf("vec%0d", i),
            {count, full, empty, date, date_vld, sent_cnt, underrun, overflow},
            {tbl[i].cnt, tbl[i].fl, tbl[i].em, tbl[i].dt, tbl[i].vl,
             tbl[i].st, tbl[i].un, tbl[i].ov});
    end

    // Overflow with ack held high
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge sclk);
      ack = 1'b1;
      wr_en = 1'b1;
      wr_data = 4'(k + 1);
      @(posedge sclk); #1;
      if (k == 0) check("ov_first", {count, date_vld}, {4'd1, 1'b0});
      if (k == 7) check("ov_full8", {count, full, overflow}, {4'd8, 1'b1, 1'b0});
    end
    @(negedge sclk);
    wr_en = 1'b0;
    ack = 1'b0;
    @(posedge sclk); #1;
    check("ov_flag", {count, full, overflow}, {4'd8, 1'b1, 1'b1});
    @(posedge sclk); #1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("ov_word%0d", k), {date_vld, date}, {1'b1, 4'(k)});
      ack_pulse();
    end
    check("ov_done", {date_vld, sent_cnt, empty}, {1'b0, 8'd8, 1'b1});

    // Write while ack is high
    do_reset();
    @(negedge sclk) begin wr_en = 1'b1; wr_data = 4'h7; end
    @(negedge sclk) wr_en = 1'b0;
    @(posedge sclk); #1;
    check("wa_first", {date_vld, date}, {1'b1, 4'h7});
    @(negedge sclk) begin ack = 1'b1; wr_en = 1'b1; wr_data = 4'h3; end
    @(negedge sclk) wr_en = 1'b0;
    @(posedge sclk); #1;
    check("wa_hold", {date, count}, {4'h7, 4'd1});
    @(negedge sclk) ack = 1'b0;
    @(posedge sclk); #1;
    check("wa_fall", {date_vld, date, sent_cnt}, {1'b0, 4'h0, 8'd1});
    @(posedge sclk); #1;
    check("wa_next", {date_vld, date}, {1'b1, 4'h3});

    // Reset mid-frame with words stored
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge sclk);
      ack = 1'b1;
      wr_en = 1'b1;
      wr_data = 4'(k + 2);
    end
    @(negedge sclk) wr_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("mid_rst", {count, empty, date_vld}, {4'd0, 1'b1, 1'b0});
    @(negedge sclk) begin ack = 1'b0; rst = 1'b1; end

    // System check with transmitter model
    @(negedge sclk) begin wr_en = 1'b1; wr_data = 4'h9; end
    @(negedge sclk) wr_data = 4'h6;
    @(negedge sclk) wr_en = 1'b0;
    tx_frame(w, ok);
    check("sys_ok0", {31'd0, ok}, 32'd1);
    check("sys_w0", {28'd0, w}, {28'd0, 4'b1001});
    tx_frame(w, ok);
    check("sys_ok1", {31'd0, ok}, 32'd1);
    check("sys_w1", {28'd0, w}, {28'd0, 4'b0110});
    check("sys_sent", {24'd0, sent_cnt}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
